riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit between `riscv_core` and the data memory bus. It accepts the core's single-cycle data request (`mem_req_o`/`mem_we_o`/`mem_size_o`/`mem_addr_o`/`mem_wd_o`) and holds the core with `stall_i` while the access runs. It then drives a word-addressed, byte-enabled, req/ready memory port. On the same path it aligns and replicates store data, and extracts and sign- or zero-extends load data.

## Interface
Parameters:
- none

Ports:
- `clk_i` in 1: clock, single domain
- `rst_i` in 1: reset, synchronous, active-high
- `core_req_i` in 1: data access request from core
- `core_we_i` in 1: 1 = store, 0 = load
- `core_size_i` in 3: funct3 size code (0 B, 1 H, 2 W, 4 BU, 5 HU)
- `core_addr_i` in 32: byte address
- `core_wd_i` in 32: store data, LSB-justified
- `core_rd_o` out 32: load data, extended
- `core_stall_o` out 1: to core `stall_i`
- `misalign_o` out 1: misaligned access pulse (see Configuration)
- `mem_req_o` out 1: bus request
- `mem_we_o` out 1: bus write
- `mem_be_o` out 4: byte enables
- `mem_addr_o` out 32: word address, `[1:0]` = 0
- `mem_wd_o` out 32: replicated store data
- `mem_rd_i` in 32: bus read data, valid with `mem_ready_i`
- `mem_ready_i` in 1: bus completion, one-cycle pulse

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - With `core_req_i` (and not misaligned): capture `we`, `size`, `addr`, `wd`; go to BUSY.
  - `core_stall_o` = 1 combinationally in the same cycle.
- BUSY
  - Outputs: `mem_req_o` = 1, `core_stall_o` = 1.
  - Bus outputs are driven from the captured registers and stay stable until `mem_ready_i`.
  - On `mem_ready_i`: register the extracted load data into `core_rd_o`; go to DONE.
- DONE
  - `core_stall_o` = 0 for exactly one cycle, so the core commits PC and writeback.
  - Go to IDLE unconditionally; `core_req_i` is ignored in this cycle.
- Byte enables:
  - B/BU: `4'b0001 << addr[1:0]`
  - H/HU: `4'b0011 << {addr[1],1'b0}`
  - W: `4'b1111`
- Store data:
  - B: `{4{wd[7:0]}}`
  - H: `{2{wd[15:0]}}`
  - W: `wd`
- Load data:
  - Select the byte at `addr[1:0]` or the halfword at `addr[1]`.
  - Sign-extend for B/H; zero-extend for BU/HU.
- Size codes 3, 6, 7 are treated as W.
- `core_rd_o` holds its value until the next load completes. Stores do not change it.

## Timing
- Reset values: state IDLE; all registered outputs 0 (`mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wd_o`, `core_rd_o`, `misalign_o`).
- `core_stall_o` is combinational: `(IDLE & core_req_i & ~misaligned) | BUSY`.
- Latency:
  - Minimum 3 cycles per access: IDLE capture, BUSY with ready, DONE.
  - Each cycle of ready delay adds one BUSY cycle.
- `mem_ready_i` outside BUSY is ignored.
- Reset in BUSY: return to IDLE; `mem_req_o` is 0 from the next cycle. The aborted access produces no data.
- Back-to-back accesses: the earliest next IDLE capture is the cycle after DONE.

## Configuration
- Macro: `RISCV_LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A halfword with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0, is misaligned.
  - In IDLE, a misaligned request raises `misalign_o` for one cycle (registered, visible the next cycle) and keeps `core_stall_o` = 0.
  - No bus access occurs and the FSM stays in IDLE.
- Undefined:
  - `misalign_o` is tied to 0.
  - Halfwords use `addr[1]` only; words ignore `addr[1:0]`.

## Structure
- `riscv_lsu_pkg` holds:
  - size localparams `LDST_B`/`LDST_H`/`LDST_W`/`LDST_BU`/`LDST_HU`;
  - the FSM state enum `lsu_state_t`.
- One sub-module, `lsu_load_align`: combinational, `(rdata, size, offset) -> extended rdata`. It is instantiated once, on `mem_rd_i` in BUSY.

## Test plan
- SB `addr`=0x1003, `wd`=0xAB, ready on the 1st BUSY cycle → `mem_addr_o`=0x1000, `mem_be_o`=4'b1000, `mem_wd_o`=0xABABABAB; `core_stall_o` high 2 cycles, then low 1 cycle.
- LB `addr`=0x2002, `mem_rd_i`=0x00F00000 → `core_rd_o`=0xFFFFFFF0. LBU on the same data → 0x000000F0.
- LH `addr`=0x2002, `mem_rd_i`=0x80010000 → `core_rd_o`=0xFFFF8001. LHU → 0x00008001.
- LW with `mem_ready_i` delayed 5 cycles → `mem_req_o` high and bus outputs stable for 5 cycles; `core_stall_o` high 6 cycles, DONE unstalled.
- `rst_i` pulse in BUSY → `mem_req_o`=0 the next cycle; `core_rd_o`=0; a subsequent SW completes normally.
- With the macro defined, LW `addr`=0x1002 → `misalign_o` pulses, `mem_req_o` never asserts, `core_stall_o`=0. Without the macro → `mem_addr_o`=0x1000, `mem_be_o`=4'b1111.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared types for the load/store unit: funct3 size codes, FSM states and
// the byte-lane helpers used on the store path.
package riscv_lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_t;

   function automatic logic size_is_byte(input logic [2:0] size);
      return (size == LDST_B) || (size == LDST_BU);
   endfunction

   function automatic logic size_is_half(input logic [2:0] size);
      return (size == LDST_H) || (size == LDST_HU);
   endfunction

   // Unused codes (3, 6, 7) fall through to the word case.
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] offset);
      if (size_is_byte(size)) return 4'b0001 << offset;
      if (size_is_half(size)) return 4'b0011 << {offset[1], 1'b0};
      return 4'b1111;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
      if (size_is_byte(size)) return {4{wd[7:0]}};
      if (size_is_half(size)) return {2{wd[15:0]}};
      return wd;
   endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Load data extraction: picks the addressed byte/halfword from a bus word
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
   import riscv_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   output logic [31:0] ext
);

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   always_comb begin
      sel_b = rdata[7:0];
      case (offset)
         2'd1:    sel_b = rdata[15:8];
         2'd2:    sel_b = rdata[23:16];
         2'd3:    sel_b = rdata[31:24];
         default: sel_b = rdata[7:0];
      endcase
      // Halfwords only look at offset[1]; offset[0] is a misalignment concern upstream.
      sel_h = offset[1] ? rdata[31:16] : rdata[15:0];

      ext = rdata;
      if (size_is_byte(size))
         ext = (size == LDST_BU) ? {24'b0, sel_b} : {{24{sel_b[7]}}, sel_b};
      else if (size_is_half(size))
         ext = (size == LDST_HU) ? {16'b0, sel_h} : {{16{sel_h[15]}}, sel_h};
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit bridging the core's single-cycle data request to a
// word-addressed req/ready bus. Optional trap on misaligned H/W: RISCV_LSU_MISALIGN_TRAP_EN.
module riscv_lsu
   import riscv_lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        misalign_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   // Bus handshake: mem_req_o rises with the access and every bus output holds
   // steady until the cycle mem_ready_i is sampled high; mem_rd_i is only
   // meaningful in that cycle. Ready outside BUSY is ignored.

   lsu_state_t  state_q;
   logic [2:0]  size_q;
   logic [1:0]  offset_q;
   logic        misaligned;
   logic        accept;
   logic [31:0] load_data;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
   assign misaligned = (size_is_half(core_size_i) && core_addr_i[0]) ||
                       (!size_is_byte(core_size_i) && !size_is_half(core_size_i) &&
                        (core_addr_i[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign accept       = (state_q == ST_IDLE) && core_req_i && !misaligned;
   assign core_stall_o = accept || (state_q == ST_BUSY);

   lsu_load_align u_load_align (
      .rdata  (mem_rd_i),
      .size   (size_q),
      .offset (offset_q),
      .ext    (load_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         size_q     <= 3'd0;
         offset_q   <= 2'd0;
         core_rd_o  <= 32'd0;
         misalign_o <= 1'b0;
         mem_req_o  <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_be_o   <= 4'd0;
         mem_addr_o <= 32'd0;
         mem_wd_o   <= 32'd0;
      end else begin
         misalign_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               misalign_o <= core_req_i && misaligned;
               if (accept) begin
                  state_q    <= ST_BUSY;
                  size_q     <= core_size_i;
                  offset_q   <= core_addr_i[1:0];
                  mem_req_o  <= 1'b1;
                  mem_we_o   <= core_we_i;
                  mem_be_o   <= byte_en(core_size_i, core_addr_i[1:0]);
                  mem_addr_o <= {core_addr_i[31:2], 2'b00};
                  mem_wd_o   <= store_data(core_size_i, core_wd_i);
               end
            end
            ST_BUSY: begin
               if (mem_ready_i) begin
                  state_q   <= ST_DONE;
                  mem_req_o <= 1'b0;
                  if (!mem_we_o) core_rd_o <= load_data;
               end
            end
            // One unstalled cycle lets the core commit; requests are not taken here.
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a vector table of complete accesses plus
// hand sequences for reset-in-BUSY, stray ready, DONE-ignores-req and misalignment.
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        misalign_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   riscv_lsu dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_size_i  (core_size_i),
      .core_addr_i  (core_addr_i),
      .core_wd_i    (core_wd_i),
      .core_rd_o    (core_rd_o),
      .core_stall_o (core_stall_o),
      .misalign_o   (misalign_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wd_o     (mem_wd_o),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_i  (mem_ready_i)
   );

   // Clock
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          busy;      // BUSY cycles; ready is given on the last one
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_rd;    // loads only; stores keep the previous value
   } vec_t;

   localparam int NVEC = 13;
   vec_t        vecs[NVEC];
   logic [31:0] exp_q[$];
   logic [31:0] last_rd;
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd);
      core_req_i  = 1'b1;
      core_we_i   = we;
      core_size_i = size;
      core_addr_i = addr;
      core_wd_i   = wd;
   endtask

   task automatic idle_core();
      core_req_i  = 1'b0;
      core_we_i   = 1'b0;
      core_size_i = 3'd0;
      core_addr_i = 32'h0;
      core_wd_i   = 32'h0;
   endtask

   // One full access starting in IDLE; returns in the following IDLE cycle.
   task automatic run_access(input vec_t v);
      int stall_hi;
      logic [31:0] exp;
      stall_hi = 0;
      exp_q.push_back(v.we ? last_rd : v.exp_rd);
      drive_req(v.we, v.size, v.addr, v.wd);
      #1;
      if (core_stall_o) stall_hi++;
      check("capture_stall", {31'b0, core_stall_o}, 32'd1);
      tick();
      idle_core();
      core_wd_i = 32'h5A5A5A5A;
      for (int i = 1; i <= v.busy; i++) begin
         check("busy_req", {31'b0, mem_req_o}, 32'd1);
         check("busy_we", {31'b0, mem_we_o}, {31'b0, v.we});
         check("busy_addr", mem_addr_o, v.exp_addr);
         check("busy_be", {28'b0, mem_be_o}, {28'b0, v.exp_be});
         if (v.we) check("busy_wd", mem_wd_o, v.exp_wd);
         if (core_stall_o) stall_hi++;
         if (i == v.busy) begin
            mem_ready_i = 1'b1;
            mem_rd_i    = v.rdata;
         end
         tick();
         mem_ready_i = 1'b0;
         mem_rd_i    = 32'hDEADBEEF;
      end
      exp = exp_q.pop_front();
      check("done_stall", {31'b0, core_stall_o}, 32'd0);
      check("done_req", {31'b0, mem_req_o}, 32'd0);
      check("done_rd", core_rd_o, exp);
      check("stall_cycles", stall_hi, v.busy + 1);
      last_rd = exp;
      tick();
   endtask

   initial begin
      vec_t v;
      // Vector table
      vecs[0]  = '{1'b1, LDST_B,  32'h0000_1003, 32'h0000_00AB, 32'h0,         1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0};
      vecs[1]  = '{1'b0, LDST_B,  32'h0000_2002, 32'h0,         32'h00F0_0000, 1, 32'h0000_2000, 4'b0100, 32'h0,         32'hFFFF_FFF0};
      vecs[2]  = '{1'b0, LDST_BU, 32'h0000_2002, 32'h0,         32'h00F0_0000, 1, 32'h0000_2000, 4'b0100, 32'h0,         32'h0000_00F0};
      vecs[3]  = '{1'b0, LDST_H,  32'h0000_2002, 32'h0,         32'h8001_0000, 1, 32'h0000_2000, 4'b1100, 32'h0,         32'hFFFF_8001};
      vecs[4]  = '{1'b0, LDST_HU, 32'h0000_2002, 32'h0,         32'h8001_0000, 1, 32'h0000_2000, 4'b1100, 32'h0,         32'h0000_8001};
      vecs[5]  = '{1'b0, LDST_W,  32'h0000_3000, 32'h0,         32'h1234_5678, 5, 32'h0000_3000, 4'b1111, 32'h0,         32'h1234_5678};
      vecs[6]  = '{1'b1, LDST_H,  32'h0000_4002, 32'hCAFE_1234, 32'h0,         2, 32'h0000_4000, 4'b1100, 32'h1234_1234, 32'h0};
      vecs[7]  = '{1'b1, LDST_W,  32'h0000_5004, 32'hA5A5_0F0F, 32'h0,         1, 32'h0000_5004, 4'b1111, 32'hA5A5_0F0F, 32'h0};
      vecs[8]  = '{1'b0, LDST_B,  32'h0000_6001, 32'h0,         32'h0000_7F00, 1, 32'h0000_6000, 4'b0010, 32'h0,         32'h0000_007F};
      vecs[9]  = '{1'b0, LDST_H,  32'h0000_6000, 32'h0,         32'h1234_FFFE, 3, 32'h0000_6000, 4'b0011, 32'h0,         32'hFFFF_FFFE};
      vecs[10] = '{1'b0, 3'd3,    32'h0000_7000, 32'h0,         32'h89AB_CDEF, 1, 32'h0000_7000, 4'b1111, 32'h0,         32'h89AB_CDEF};
      vecs[11] = '{1'b1, 3'd6,    32'h0000_7008, 32'h0102_0304, 32'h0,         1, 32'h0000_7008, 4'b1111, 32'h0102_0304, 32'h0};
      vecs[12] = '{1'b0, LDST_BU, 32'h0000_8003, 32'h0,         32'h9A00_0000, 2, 32'h0000_8000, 4'b1000, 32'h0,         32'h0000_009A};

      // Reset
      rst_i       = 1'b1;
      mem_ready_i = 1'b0;
      mem_rd_i    = 32'h0;
      idle_core();
      last_rd     = 32'h0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("rst_req", {31'b0, mem_req_o}, 32'd0);
      check("rst_we", {31'b0, mem_we_o}, 32'd0);
      check("rst_be", {28'b0, mem_be_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_wd", mem_wd_o, 32'd0);
      check("rst_rd", core_rd_o, 32'd0);
      check("rst_misalign", {31'b0, misalign_o}, 32'd0);
      check("rst_stall", {31'b0, core_stall_o}, 32'd0);
      tick();

      for (int i = 0; i < NVEC; i++) run_access(vecs[i]);

      // Stray ready in IDLE must be ignored
      mem_ready_i = 1'b1;
      mem_rd_i    = 32'hFFFF_FFFF;
      #1;
      check("stray_stall", {31'b0, core_stall_o}, 32'd0);
      tick();
      mem_ready_i = 1'b0;
      check("stray_req", {31'b0, mem_req_o}, 32'd0);
      check("stray_rd", core_rd_o, last_rd);
      tick();

      // Request held through DONE is ignored; next IDLE captures back-to-back
      drive_req(1'b0, LDST_W, 32'h0000_A000, 32'h0);
      tick();
      mem_ready_i = 1'b1;
      mem_rd_i    = 32'h0000_BEEF;
      check("b2b_busy_req", {31'b0, mem_req_o}, 32'd1);
      tick();
      mem_ready_i = 1'b0;
      check("b2b_done_stall", {31'b0, core_stall_o}, 32'd0);
      check("b2b_done_rd", core_rd_o, 32'h0000_BEEF);
      tick();
      check("b2b_idle_stall", {31'b0, core_stall_o}, 32'd1);
      tick();
      idle_core();
      check("b2b_busy2_req", {31'b0, mem_req_o}, 32'd1);
      mem_ready_i = 1'b1;
      mem_rd_i    = 32'h0000_0001;
      tick();
      mem_ready_i = 1'b0;
      check("b2b_done2_rd", core_rd_o, 32'h0000_0001);
      last_rd = 32'h0000_0001;
      tick();

      // Reset while BUSY aborts the access
      drive_req(1'b0, LDST_W, 32'h0000_9000, 32'h0);
      tick();
      idle_core();
      check("abort_busy_req", {31'b0, mem_req_o}, 32'd1);
      rst_i       = 1'b1;
      mem_ready_i = 1'b1;
      mem_rd_i    = 32'h7777_7777;
      tick();
      rst_i       = 1'b0;
      mem_ready_i = 1'b0;
      check("abort_req", {31'b0, mem_req_o}, 32'd0);
      check("abort_rd", core_rd_o, 32'd0);
      check("abort_stall", {31'b0, core_stall_o}, 32'd0);
      last_rd = 32'h0;
      tick();
      v = '{1'b1, LDST_W, 32'h0000_B000, 32'h0BAD_F00D, 32'h0, 1, 32'h0000_B000, 4'b1111, 32'h0BAD_F00D, 32'h0};
      run_access(v);

      // Misaligned word
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      drive_req(1'b0, LDST_W, 32'h0000_1002, 32'h0);
      #1;
      check("mis_stall", {31'b0, core_stall_o}, 32'd0);
      tick();
      idle_core();
      check("mis_pulse", {31'b0, misalign_o}, 32'd1);
      check("mis_req", {31'b0, mem_req_o}, 32'd0);
      tick();
      check("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
      check("mis_req2", {31'b0, mem_req_o}, 32'd0);
      tick();
`else
      v = '{1'b0, LDST_W, 32'h0000_1002, 32'h0, 32'h1122_3344, 1, 32'h0000_1000, 4'b1111, 32'h0, 32'h1122_3344};
      run_access(v);
      check("mis_off", {31'b0, misalign_o}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
